muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 15 +
 rtl/muldiv_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between a muldiv requester and the unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic             Abort;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A_In;
  logic [WIDTH-1:0] B_In;
  logic             Busy;
  logic             Done;
  logic             Div_Zero;
  logic [WIDTH-1:0] HI_Out;
  logic [WIDTH-1:0] LO_Out;
  modport master (output Start, Abort, Op, A_In, B_In, input Busy, Done, Div_Zero, HI_Out, LO_Out);
  modport slave (input Start, Abort, Op, A_In, B_In, output Busy, Done, Div_Zero, HI_Out, LO_Out);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 signed/unsigned multiply and restoring divide
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic          Clock,
  input logic          Reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mb_q, mb_d, hi_q, hi_d, lo_q, lo_d, rhi_q, rhi_d, rlo_q, rlo_d;
  logic [WIDTH:0] sum, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic a_neg, b_neg, zero_div;
  always_comb begin
    a_neg = ~bus.Op[0] & bus.A_In[WIDTH-1];
    b_neg = ~bus.Op[0] & bus.B_In[WIDTH-1];
    a_abs = a_neg ? -bus.A_In : bus.A_In;
    b_abs = b_neg ? -bus.B_In : bus.B_In;
    zero_div = bus.Op[1] & (bus.B_In == '0);
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    // top bit of the trial difference is the borrow: set means divisor did not fit
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, mb_q};
    prod_fix = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    q_fix = (sa_q ^ sb_q) ? -lo_q : lo_q;
    r_fix = sa_q ? -hi_q : hi_q;
  end
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    sa_d = sa_q;
    sb_d = sb_q;
    dz_d = dz_q;
    cnt_d = cnt_q;
    mb_d = mb_q;
    hi_d = hi_q;
    lo_d = lo_q;
    rhi_d = rhi_q;
    rlo_d = rlo_q;
    case (state_q)
      IDLE: if (bus.Start) begin
        state_d = zero_div ? DONE : RUN;
        dz_d = zero_div;
        div_d = bus.Op[1];
        sa_d = a_neg;
        sb_d = b_neg;
        mb_d = b_abs;
        hi_d = '0;
        lo_d = a_abs;
        cnt_d = '0;
      end
      RUN: if (bus.Abort) state_d = IDLE;
      else begin
        hi_d = div_q ? (trial[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : trial[WIDTH-1:0]) : sum[WIDTH:1];
        lo_d = div_q ? {lo_q[WIDTH-2:0], ~trial[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
      end
      FIX: if (bus.Abort) state_d = IDLE;
      else begin
        {rhi_d, rlo_d} = div_q ? {r_fix, q_fix} : prod_fix;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      div_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      dz_q <= 1'b0;
      cnt_q <= '0;
      mb_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      rhi_q <= '0;
      rlo_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      dz_q <= dz_d;
      cnt_q <= cnt_d;
      mb_q <= mb_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      rhi_q <= rhi_d;
      rlo_q <= rlo_d;
    end
  end
  assign bus.Busy = state_q != IDLE;
  assign bus.Done = state_q == DONE;
  assign bus.Div_Zero = dz_q;
  assign bus.HI_Out = rhi_q;
  assign bus.LO_Out = rlo_q;
endmodule
